eight_wallace: RTL and testbench

Unsigned 8×8 multiplier built as a Wallace-tree carry-save reduction followed by a single carry-propagate adder, with a registered result. It sits in the arithmetic datapath as the fixed-width multiply primitive: one product per clock, accepted every cycle, no stalls.

---
 rtl/eight_wallace_pkg.sv | 19 +
 rtl/eight_wallace_full_adder.sv | 11 +
 rtl/eight_wallace.sv | 57 +++++
 tb/tb_eight_wallace.sv | 101 ++++++++++
 4 files changed

// File: rtl/eight_wallace_pkg.sv
// eight_wallace_pkg: widths, pipeline latency and Wallace-tree row map (LAT tracks EIGHT_WALLACE_IN_REG_EN)
package eight_wallace_pkg;
  localparam int OP_W = 8;
  localparam int PROD_W = 16;
`ifdef EIGHT_WALLACE_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  // Rows 0-7 partial products, then 8-13, 14-17, 18-20 and 21-22 per reduction stage (8>6>4>3>2)
  localparam int NROWS = 23;
  localparam int NGRP = 6;
  localparam int NPASS = 3;
  localparam int GRP_IN [NGRP] = '{0, 3, 8, 11, 14, 18};
  localparam int GRP_OUT [NGRP] = '{8, 10, 14, 16, 18, 21};
  localparam int PASS_SRC [NPASS] = '{6, 7, 17};
  localparam int PASS_DST [NPASS] = '{12, 13, 20};
  localparam int FIN = NROWS - 2;
endpackage

// File: rtl/eight_wallace_full_adder.sv
// full_adder: one-bit 3:2 compressor; with z tied low it acts as a half adder
module full_adder (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic s,
  output logic co
);
  assign s = x ^ y ^ z;
  assign co = (x & y) | (x & z) | (y & z);
endmodule

// File: rtl/eight_wallace.sv
// eight_wallace: registered unsigned 8x8 Wallace-tree multiplier; EIGHT_WALLACE_IN_REG_EN adds an input register stage
module eight_wallace
  import eight_wallace_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic              out_valid,
  output logic [PROD_W-1:0] prod
);
  logic [OP_W-1:0] a_t, b_t;
  logic v_t;
`ifdef EIGHT_WALLACE_IN_REG_EN
  always_ff @(posedge clk) begin
    a_t <= rst ? '0 : a;
    b_t <= rst ? '0 : b;
    v_t <= rst ? 1'b0 : in_valid;
  end
`else
  assign a_t = a;
  assign b_t = b;
  assign v_t = in_valid;
`endif
  logic [PROD_W-1:0] row [NROWS];
  for (genvar i = 0; i < OP_W; i++) begin : g_pp
    assign row[i] = PROD_W'(a_t & {OP_W{b_t[i]}}) << i;
  end
  // Each group compresses three rows into a sum row and a left-shifted carry row
  for (genvar g = 0; g < NGRP; g++) begin : g_csa
    localparam int I = GRP_IN[g];
    localparam int O = GRP_OUT[g];
    logic [PROD_W-1:0] s;
    logic [PROD_W-2:0] c;
    for (genvar k = 0; k < PROD_W - 1; k++) begin : g_fa
      full_adder u_fa (.x(row[I][k]), .y(row[I+1][k]), .z(row[I+2][k]), .s(s[k]), .co(c[k]));
    end
    assign s[PROD_W-1] = row[I][PROD_W-1] ^ row[I+1][PROD_W-1] ^ row[I+2][PROD_W-1];
    assign row[O] = s;
    assign row[O+1] = {c, 1'b0};
  end
  for (genvar p = 0; p < NPASS; p++) begin : g_pass
    assign row[PASS_DST[p]] = row[PASS_SRC[p]];
  end
  // Ripple CPA; the carry out of the top bit is always 0 for 8-bit operands, so it is never formed
  logic [PROD_W-1:0] sum, cy;
  assign cy[0] = 1'b0;
  for (genvar k = 0; k < PROD_W - 1; k++) begin : g_cpa
    full_adder u_fa (.x(row[FIN][k]), .y(row[FIN+1][k]), .z(cy[k]), .s(sum[k]), .co(cy[k+1]));
  end
  assign sum[PROD_W-1] = row[FIN][PROD_W-1] ^ row[FIN+1][PROD_W-1] ^ cy[PROD_W-1];
  always_ff @(posedge clk) begin
    prod <= rst ? '0 : sum;
    out_valid <= rst ? 1'b0 : v_t;
  end
endmodule

// File: tb/tb_eight_wallace.sv
// tb_eight_wallace: random/exhaustive stimulus with a queue scoreboard checked against a*b at latency LAT
module tb_eight_wallace;
  import eight_wallace_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic out_valid;
  logic [15:0] prod;

  eight_wallace dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
    .out_valid(out_valid), .prod(prod)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] p;
    int          due;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int cyc = 0;
  int checks = 0;
  int fails = 0;
  logic rst_seen = 1'b0;

  // Reference: every accepted operand pair yields a*b exactly LAT edges later; reset discards anything not yet delivered
  always @(posedge clk) begin
    cyc = cyc + 1;
    rst_seen = rst;
    if (rst) q.delete();
    else if (in_valid) q.push_back('{p: 16'(a) * 16'(b), due: cyc + LAT - 1});
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      if (rst_seen) begin
        checks++;
        if (out_valid !== 1'b0 || prod !== 16'h0000) begin
          fails++;
          $display("FAIL reset: out_valid=%b prod=%h, required 0 and 0000 (cycle %0d)", out_valid, prod, cyc);
        end
      end else if (out_valid === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected: out_valid=1 prod=%h with no result pending (cycle %0d)", prod, cyc);
        end else begin
          e = q.pop_front();
          if (prod !== e.p || cyc != e.due) begin
            fails++;
            $display("FAIL product: prod=%h at cycle %0d, required %h at cycle %0d", prod, cyc, e.p, e.due);
          end
        end
      end else if (q.size() > 0 && q[0].due <= cyc) begin
        checks++;
        fails++;
        e = q.pop_front();
        $display("FAIL missing: out_valid=%b at cycle %0d, required 1 with prod %h", out_valid, cyc, e.p);
      end
    end
  end

  task automatic step(input logic [7:0] x, input logic [7:0] y, input logic v, input logic r);
    @(negedge clk);
    a = x;
    b = y;
    in_valid = v;
    rst = r;
  endtask

  initial begin
    logic [7:0] ca [5];
    logic [7:0] cb [5];
    ca = '{8'd0, 8'd1, 8'd255, 8'd128, 8'd255};
    cb = '{8'd0, 8'd255, 8'd1, 8'd2, 8'd255};
    for (int i = 0; i < 3; i++) step(8'd255, 8'd255, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(ca[i], cb[i], 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(8'd0, 8'd0, 1'b0, 1'b0);
    for (int i = 0; i < 256; i++)
      for (int j = 0; j < 256; j++) step(8'(i), 8'(j), 1'b1, 1'b0);
    for (int i = 0; i < 200; i++) step(8'($urandom), 8'($urandom), 1'(i % 2 == 0), 1'b0);
    for (int i = 0; i < 200; i++) step(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    for (int i = 0; i < 5; i++) step(8'd200, 8'd200, 1'b1, 1'b0);
    step(8'd200, 8'd200, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(8'd200, 8'd200, 1'b1, 1'b0);
    for (int i = 0; i < 30; i++) step(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) == 0));
    for (int i = 0; i < LAT + 3; i++) step(8'd0, 8'd0, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d results never delivered, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
